// File: rtl/bbox_pkg.sv
// bbox_pkg: shared image geometry, derived widths and FSM states for the bounding-box scan controller
package bbox_pkg;
  localparam int DEF_IMG_W = 100;
  localparam int DEF_IMG_H = 100;
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
  function automatic int addr_w(input int w, input int h);
    return clog2_min1(w * h);
  endfunction
  function automatic int coord_w(input int w, input int h);
    return clog2_min1((w > h) ? w : h);
  endfunction
  localparam int ADDR_W = addr_w(DEF_IMG_W, DEF_IMG_H);
  localparam int COORD_W = coord_w(DEF_IMG_W, DEF_IMG_H);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;
endpackage

// File: rtl/bbox_raster_counter.sv
// bbox_raster_counter: raster-order x/y/address counters advanced one pixel per enable
module bbox_raster_counter import bbox_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW = addr_w(IMG_W, IMG_H),
  parameter int CW = coord_w(IMG_W, IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic wrap;
  assign wrap = x_q == CW'(IMG_W - 1);
  assign last_o = addr_q == AW'(IMG_W * IMG_H - 1);
  assign x_o = x_q;
  assign y_o = y_q;
  assign addr_o = addr_q;
  // address is its own counter so no y*IMG_W product is needed; the final pixel returns everything to 0
  always_comb begin
    x_d = clr_i ? '0 : !en_i ? x_q : wrap ? '0 : x_q + CW'(1);
    y_d = clr_i ? '0 : !(en_i && wrap) ? y_q : last_o ? '0 : y_q + CW'(1);
    addr_d = clr_i ? '0 : !en_i ? addr_q : last_o ? '0 : addr_q + AW'(1);
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/bbox_scan_ctrl.sv
// bbox_scan_ctrl: raster-scans an IMG_W x IMG_H image RAM and tags each returned pixel for a bounding-box datapath
// Optional SCAN_STALL_EN adds ram_ready; a low ram_ready in SCAN suppresses the read and holds the counters
module bbox_scan_ctrl import bbox_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  localparam int AW = addr_w(IMG_W, IMG_H),
  localparam int CW = coord_w(IMG_W, IMG_H)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
`ifdef SCAN_STALL_EN
  input  logic          ram_ready,
`endif
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_first,
  output logic          pix_last,
  output logic          busy,
  output logic          done
);
  state_e state_q, state_d;
  logic rdy, last;
  logic [CW-1:0] x, y;
  logic pix_valid_q, pix_first_q, pix_last_q;
  logic [CW-1:0] pix_x_q, pix_y_q;
`ifdef SCAN_STALL_EN
  assign rdy = ram_ready;
`else
  assign rdy = 1'b1;
`endif
  bbox_raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .CW(CW)) u_cnt (
    .clk(CLOCK_50),
    .rst(reset),
    .clr_i(!busy),
    .en_i(ram_rd),
    .x_o(x),
    .y_o(y),
    .addr_o(ram_addr),
    .last_o(last)
  );
  // next state and status; abort beats start and suppresses the read it coincides with
  always_comb begin
    state_d = state_q;
    ram_rd = (state_q == SCAN) && rdy && !abort;
    busy = (state_q == SCAN) || (state_q == DRAIN);
    done = state_q == DONE;
    case (state_q)
      IDLE, DONE: state_d = abort ? IDLE : start ? SCAN : state_q;
      SCAN: state_d = abort ? IDLE : (ram_rd && last) ? DRAIN : SCAN;
      DRAIN: state_d = abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // pixel tags trail the read by one cycle to line up with the RAM's registered output
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_first_q <= 1'b0;
      pix_last_q <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else begin
      pix_valid_q <= ram_rd;
      pix_first_q <= ram_rd && (ram_addr == '0);
      pix_last_q <= ram_rd && last;
      pix_x_q <= x;
      pix_y_q <= y;
    end
  end
  assign pix_valid = pix_valid_q;
  assign pix_first = pix_first_q;
  assign pix_last = pix_last_q;
  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// tb_bbox_scan_ctrl: randomized scoreboard bench for bbox_scan_ctrl (honours SCAN_STALL_EN when defined)
module tb_bbox_scan_ctrl;
  localparam int W = 100;
  localparam int H = 100;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ram_rd, pix_valid, pix_first, pix_last, busy, done;
  logic [13:0] ram_addr;
  logic [6:0] pix_x, pix_y;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int npix = 0;
  int rd_q[$];
  int px_q[$];
`ifdef SCAN_STALL_EN
  logic ram_ready = 1'b1;
  int stalls_left = 3;
`endif

  bbox_scan_ctrl dut (
    .CLOCK_50(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
`ifdef SCAN_STALL_EN
    .ram_ready(ram_ready),
`endif
    .ram_rd(ram_rd),
    .ram_addr(ram_addr),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_first(pix_first),
    .pix_last(pix_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    rd_q.delete();
    px_q.delete();
  endtask

  // monitor: every read must be the next raster address; every returned pixel carries the coordinates of its index
  always @(negedge clk) begin
    int i;
    if (ram_rd) begin
      if (rd_q.size() == 0) chk("rd_unexpected", ram_rd, 0);
      else chk("rd_addr", ram_addr, rd_q.pop_front());
    end
    if (pix_valid) begin
      if (px_q.size() == 0) chk("pix_unexpected", pix_valid, 0);
      else begin
        i = px_q.pop_front();
        chk("pix_tag", {pix_x, pix_y, pix_first, pix_last}, {7'(i % W), 7'(i / W), i == 0, i == N - 1});
        npix++;
      end
    end
  end

  // kind 0: full scan; kind 1: abort at start+ev_at; kind 2: reset at start+ev_at
  task automatic scan(input int kind, input int ev_at);
    int s;
    int nstall;
    s = cyc;
    nstall = 0;
    npix = 0;
    for (int i = 0; i < N; i++) begin
      rd_q.push_back(i);
      px_q.push_back(i);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_cycle1", {busy, done, ram_rd, ram_addr}, {3'b101, 14'd0});
    while (!done && cyc < s + N + 50) begin
      if (cyc == s + 2) chk("first_pix_cycle", {pix_valid, pix_first}, 2'b11);
      if (cyc == s + 300 || $urandom_range(0, 1999) == 0) start = 1'b1;
      if (kind == 1 && cyc == s + ev_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        flush();
        chk("abort_outputs", {busy, done, pix_valid, ram_rd}, 0);
        return;
      end
      if (kind == 2 && cyc == s + ev_at) begin
        reset = 1'b1;
        start = 1'b0;
        tick();
        flush();
        chk("reset_outputs", {ram_rd, ram_addr, pix_valid, pix_x, pix_y, pix_first, pix_last, busy, done}, 0);
        start = 1'b1;
        repeat (3) begin
          tick();
          chk("reset_start_idle", {busy, done, ram_rd, pix_valid}, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_reset_idle", {busy, done}, 0);
        return;
      end
`ifdef SCAN_STALL_EN
      ram_ready = !(stalls_left > 0 && busy && ram_addr == 14'd50);
      if (!ram_ready) begin
        stalls_left--;
        nstall++;
      end
`endif
      tick();
      start = 1'b0;
    end
`ifdef SCAN_STALL_EN
    ram_ready = 1'b1;
`endif
    chk("done_cycle", cyc - s, N + 2 + nstall);
    chk("pix_count", npix, N);
    chk("queues_drained", rd_q.size() + px_q.size(), 0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_state", {ram_rd, ram_addr, pix_valid, pix_x, pix_y, pix_first, pix_last, busy, done}, 0);
    scan(0, 0);
    repeat ($urandom_range(1, 20)) tick();
    chk("done_held", {busy, done}, 2'b01);
    scan(1, 500);
    repeat ($urandom_range(1, 10)) tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", {busy, done}, 0);
    tick();
    chk("still_idle", {busy, done, ram_rd}, 0);
    scan(2, 4000);
    scan(0, 0);
    scan(1, $urandom_range(1, N + 1));
    repeat (3) tick();
    chk("final_idle", {busy, done, pix_valid}, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
